sram_port_arb: RTL and testbench
================================

SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 Parameters SHALL be:
 M  2  matrix rows
 KMAX  2  matrix columns
 DATA_W  32  word width
 BYTE_W  DATA_W/8  byte-mask width
 RD_LAT  1  SRAM read latency in cycles, ≥1
 ROW_W and K_W  derived as max(1, clog2(M)) and max(1, clog2(KMAX))
REQ-002 Ports SHALL be (index i∈{0,1} = requester; vector ports pack requester 1 in the upper slice):
 clk  in  1  single clock, rising edge
 rst  in  1  synchronous, active-high reset
 hold  in  1  1 = issue no new grants
 req_valid  in  2  request present
 req_ready  out  2  request accepted this cycle
 req_we  in  2  1 = write, 0 = read
 req_row  in  2*ROW_W  row address
 req_k  in  2*K_W  column address
 req_wdata  in  2*DATA_W  write data
 req_wmask  in  2*BYTE_W  byte enables
 rsp_valid  out  2  read data valid, one-cycle pulse
 rsp_data  out  DATA_W  read data, shared by both requesters
 w_en, w_re, w_we  out  1 each  SRAM command
 w_row, w_k, w_wdata, w_wmask  out  ROW_W, K_W, DATA_W, BYTE_W  SRAM command fields
 w_rdata  in  DATA_W  SRAM read data
 w_rvalid  in  1  SRAM read valid
 gnt_cnt  out  2*16  per-requester grant counters
 proto_err  out  1  sticky: unexpected or missing w_rvalid
 oob_err  out  1  sticky: address out of range

Function
REQ-003 Grant logic SHALL be combinational; at most one bit of req_ready is set per cycle; req_ready is all zero when hold=1 or rst=1.
REQ-004 Single requester valid: it SHALL be granted the same cycle.
REQ-005 Both requesters valid: the grant SHALL go to rr_ptr.
REQ-006 After any grant to requester g, rr_ptr SHALL update to 1-g at the next edge.
REQ-007 The SRAM command SHALL be driven combinationally from the granted request:
 w_en = 1; w_we = req_we[g]; w_re = ~req_we[g]; address, data and mask forwarded.
REQ-008 When no grant is issued, w_en, w_re and w_we SHALL be 0, and all data outputs SHALL be 0.
REQ-009 Requesters SHALL hold every request field stable while valid=1 and ready=0; the arbiter does not buffer requests.
REQ-010 Out-of-range address (row ≥ M or k ≥ KMAX):
 - the request is still accepted;
 - w_en SHALL stay 0 and oob_err SHALL be set;
 - a read SHALL still return rsp_valid with rsp_data = 0 after RD_LAT cycles.
REQ-011 Each accept SHALL push {rd, oob, id} into a tag shift register of depth RD_LAT; a write or no-accept pushes rd = 0.
REQ-012 At the tag output, when rd = 1:
 - if oob = 0: rsp_valid[id] = w_rvalid and rsp_data = w_rdata;
 - if oob = 1: rsp_valid[id] = 1 and rsp_data = 0.
 The other requester's rsp_valid bit SHALL be 0.
REQ-013 Tag output rd = 1, oob = 0 with w_rvalid = 0, or w_rvalid = 1 with no matching tag, SHALL set proto_err; no rsp_valid is produced for the unmatched w_rvalid.
REQ-014 Back-to-back grants SHALL sustain one request per cycle, with responses returned in issue order.
REQ-015 gnt_cnt[i] SHALL increment on each grant to i and saturate at 16'hFFFF.
REQ-016 With hold = 1, in-flight reads SHALL still complete normally.

Reset
REQ-017 While rst = 1 the following SHALL be 0: rr_ptr, all tag stages, rsp_valid, req_ready, all w_* outputs, gnt_cnt, proto_err and oob_err.
REQ-018 A reset asserted mid-operation SHALL discard in-flight tags; a w_rvalid arriving during the cycle after reset deasserts SHALL produce no rsp_valid and SHALL NOT set proto_err.

Structure
REQ-019 A shared package sram_arb_pkg SHALL hold the tag struct {rd, oob, id} and the counter width constant CNT_W = 16.
REQ-020 The tag pipeline SHALL be one sub-module, sram_arb_tag_pipe, parameterised by RD_LAT.

Verification
REQ-021 Test: only req0 reads (1,1) after write 0xDEADBEEF. Required: rsp_valid = 2'b01 exactly RD_LAT cycles after accept, rsp_data = DEADBEEF.
REQ-022 Test: both requesters held valid for 6 cycles. Required: grants alternate 0,1,0,1,0,1; gnt_cnt = {3, 3}.
REQ-023 Test: req0 writes (0,0) = 0x11223344 mask 4'b1111, then req1 writes 0xAABBCCDD mask 4'b1100, then req1 reads (0,0). Required: rsp_valid[1] = 1 and rsp_data = AABB3344.
REQ-024 Test: M = 3, req0 reads row 3. Required: w_en stays 0, oob_err = 1, rsp_valid[0] with data 0 after RD_LAT cycles.
REQ-025 Test: hold = 1 for 4 cycles with both requesters valid. Required: no req_ready; after hold drops, grant goes to rr_ptr.
REQ-026 Test: pulse rst while a read is in flight. Required: outputs zero, no rsp_valid, proto_err = 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared tag type and counter width for the SRAM port arbiter
package sram_arb_pkg;
  localparam int CNT_W = 16;
  typedef struct packed {
    logic rd;
    logic oob;
    logic id;
  } tag_t;
endpackage

// File: rtl/sram_arb_tag_pipe.sv
// sram_arb_tag_pipe: RD_LAT-deep shift register of read tags
module sram_arb_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t i_tag,
  output tag_t o_tag
);
  tag_t [RD_LAT-1:0] r_sh;
  if (RD_LAT == 1) begin : g_one
    always_ff @(posedge clk) r_sh <= rst ? '0 : i_tag;
  end else begin : g_many
    always_ff @(posedge clk) r_sh <= rst ? '0 : {r_sh[RD_LAT-2:0], i_tag};
  end
  assign o_tag = r_sh[RD_LAT-1];
endmodule

// File: rtl/sram_port_arb.sv
// sram_port_arb: two-requester round-robin arbiter in front of a single-port SRAM
module sram_port_arb
  import sram_arb_pkg::*;
#(
  parameter int M      = 2,
  parameter int KMAX   = 2,
  parameter int DATA_W = 32,
  parameter int BYTE_W = DATA_W / 8,
  parameter int RD_LAT = 1,
  parameter int ROW_W  = (M > 1) ? $clog2(M) : 1,
  parameter int K_W    = (KMAX > 1) ? $clog2(KMAX) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ROW_W-1:0]    req_row,
  input  logic [2*K_W-1:0]      req_k,
  input  logic [2*DATA_W-1:0]   req_wdata,
  input  logic [2*BYTE_W-1:0]   req_wmask,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  w_en,
  output logic                  w_re,
  output logic                  w_we,
  output logic [ROW_W-1:0]      w_row,
  output logic [K_W-1:0]        w_k,
  output logic [DATA_W-1:0]     w_wdata,
  output logic [BYTE_W-1:0]     w_wmask,
  input  logic [DATA_W-1:0]     w_rdata,
  input  logic                  w_rvalid,
  output logic [2*CNT_W-1:0]    gnt_cnt,
  output logic                  proto_err,
  output logic                  oob_err
);
  logic                   r_rr_ptr;
  logic [1:0][CNT_W-1:0]  r_cnt;
  logic [RD_LAT-1:0]      r_quiet;
  logic [1:0]             w_req;
  logic                   w_any, w_gid, w_oob, w_issue, w_sel_we, w_expect;
  logic [ROW_W-1:0]       w_sel_row;
  logic [K_W-1:0]         w_sel_k;
  tag_t                   w_tag_in, w_tag_out;
  assign w_req     = req_valid & {2{~(hold | rst)}};
  assign w_any     = |w_req;
  assign w_gid     = &w_req ? r_rr_ptr : w_req[1];
  assign req_ready = w_any ? (w_gid ? 2'b10 : 2'b01) : 2'b00;
  assign w_sel_row = w_gid ? req_row[2*ROW_W-1:ROW_W] : req_row[ROW_W-1:0];
  assign w_sel_k   = w_gid ? req_k[2*K_W-1:K_W] : req_k[K_W-1:0];
  assign w_sel_we  = w_gid ? req_we[1] : req_we[0];
  assign w_oob     = (32'(w_sel_row) >= 32'(M)) || (32'(w_sel_k) >= 32'(KMAX));
  assign w_issue   = w_any & ~w_oob;
  assign w_en      = w_issue;
  assign w_we      = w_issue & w_sel_we;
  assign w_re      = w_issue & ~w_sel_we;
  assign w_row     = w_issue ? w_sel_row : '0;
  assign w_k       = w_issue ? w_sel_k : '0;
  assign w_wdata   = w_issue ? (w_gid ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0]) : '0;
  assign w_wmask   = w_issue ? (w_gid ? req_wmask[2*BYTE_W-1:BYTE_W] : req_wmask[BYTE_W-1:0]) : '0;
  assign w_tag_in  = {w_any & ~w_sel_we, w_oob, w_gid};
  sram_arb_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );
  assign w_expect  = w_tag_out.rd & ~w_tag_out.oob;
  assign rsp_valid = (rst || !w_tag_out.rd) ? 2'b00 :
                     {w_tag_out.id, ~w_tag_out.id} & {2{w_tag_out.oob | w_rvalid}};
  assign rsp_data  = (~rst & w_expect & w_rvalid) ? w_rdata : '0;
  assign gnt_cnt   = r_cnt;
  always_ff @(posedge clk) begin
    r_rr_ptr  <= rst ? 1'b0 : (w_any ? ~w_gid : r_rr_ptr);
    r_quiet   <= rst ? '1 : r_quiet >> 1;
    oob_err   <= ~rst & (oob_err | (w_any & w_oob));
    proto_err <= ~rst & (proto_err | (~r_quiet[0] & (w_expect ^ w_rvalid)));
    for (int i = 0; i < 2; i++)
      r_cnt[i] <= rst ? '0 : r_cnt[i] + CNT_W'(w_any && (w_gid == i[0]) && (r_cnt[i] != '1));
  end
endmodule

// File: tb/tb_sram_port_arb.sv
// tb_sram_port_arb: directed self-checking bench for sram_port_arb with a behavioural SRAM
module tb_sram_port_arb;
  localparam int M = 3, KMAX = 2, DW = 32, BW = 4, RW = 2, KW = 1;
  logic             clk = 1'b0, rst = 1'b1, hold = 1'b0;
  logic [1:0]       req_valid = '0, req_we = '0;
  logic [2*RW-1:0]  req_row = '0;
  logic [2*KW-1:0]  req_k = '0;
  logic [2*DW-1:0]  req_wdata = '0;
  logic [2*BW-1:0]  req_wmask = '0;
  logic [1:0]       req_ready, rsp_valid;
  logic [DW-1:0]    rsp_data, w_wdata, w_rdata;
  logic             w_en, w_re, w_we, w_rvalid, proto_err, oob_err;
  logic [RW-1:0]    w_row;
  logic [KW-1:0]    w_k;
  logic [BW-1:0]    w_wmask;
  logic [31:0]      gnt_cnt;
  logic             sram_rv = 1'b0, inj_rv = 1'b0, drop_rv = 1'b0;
  logic [31:0]      sram_rd = '0;
  logic [31:0]      mem [6];
  int               total = 0, bad = 0;

  sram_port_arb #(.M(M), .KMAX(KMAX), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_row(req_row), .req_k(req_k), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .w_en(w_en),
    .w_re(w_re), .w_we(w_we), .w_row(w_row), .w_k(w_k), .w_wdata(w_wdata),
    .w_wmask(w_wmask), .w_rdata(w_rdata), .w_rvalid(w_rvalid), .gnt_cnt(gnt_cnt),
    .proto_err(proto_err), .oob_err(oob_err)
  );

  always #5 clk = ~clk;
  assign w_rvalid = (sram_rv & ~drop_rv) | inj_rv;
  assign w_rdata  = sram_rd;

  always @(posedge clk) begin
    sram_rv <= w_en & w_re;
    if (w_en && w_re) sram_rd <= mem[int'(w_row) * KMAX + int'(w_k)];
    if (rst) begin
      for (int i = 0; i < 6; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (w_en && w_we) begin
      for (int b = 0; b < 4; b++)
        if (w_wmask[b]) mem[int'(w_row) * KMAX + int'(w_k)][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0; req_we = '0; req_row = '0; req_k = '0; req_wdata = '0; req_wmask = '0;
  endtask

  task automatic drive(input int i, input logic we, input logic [1:0] row, input logic k,
                       input logic [31:0] d, input logic [3:0] m);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_row[i*RW +: RW] = row;
    req_k[i] = k;
    req_wdata[i*DW +: DW] = d;
    req_wmask[i*BW +: BW] = m;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); hold = 1'b0; inj_rv = 1'b0; drop_rv = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b0, 2'd0, 1'b0, 32'h0, 4'h0);
    drive(1, 1'b1, 2'd1, 1'b1, 32'hFFFF_FFFF, 4'hF);
    cyc(); cyc(); #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b want=00", req_ready); end
    total++; if ({w_en, w_re, w_we} !== 3'b000) begin bad++; $display("FAIL rst_cmd got=%b want=000", {w_en, w_re, w_we}); end
    total++; if (w_wdata !== 32'h0 || w_row !== 2'd0) begin bad++; $display("FAIL rst_fields got=%h/%h want=0/0", w_wdata, w_row); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_rsp got=%b want=00", rsp_valid); end
    total++; if (gnt_cnt !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%h want=0", gnt_cnt); end
    total++; if ({proto_err, oob_err} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b want=00", {proto_err, oob_err}); end
    rst = 1'b0; idle();
    cyc();
  endtask

  task automatic test_read();
    idle(); drive(0, 1'b1, 2'd1, 1'b1, 32'hDEAD_BEEF, 4'hF); #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL wr_ready got=%b want=01", req_ready); end
    total++; if ({w_en, w_re, w_we} !== 3'b101) begin bad++; $display("FAIL wr_cmd got=%b want=101", {w_en, w_re, w_we}); end
    total++; if (w_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_data got=%h want=deadbeef", w_wdata); end
    cyc();
    idle(); drive(0, 1'b0, 2'd1, 1'b1, 32'h0, 4'h0); #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rd_ready got=%b want=01", req_ready); end
    total++; if ({w_en, w_re, w_we, w_row, w_k} !== 6'b110011) begin bad++; $display("FAIL rd_cmd got=%b want=110011", {w_en, w_re, w_we, w_row, w_k}); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL wr_no_rsp got=%b want=00", rsp_valid); end
    cyc();
    idle(); #1;
    total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL rd_rsp_valid got=%b want=01", rsp_valid); end
    total++; if (rsp_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_rsp_data got=%h want=deadbeef", rsp_data); end
    cyc(); #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rd_pulse got=%b want=00", rsp_valid); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rd_proto got=%b want=0", proto_err); end
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_r;
    logic [31:0] exp_d;
    do_reset();
    drive(0, 1'b0, 2'd0, 1'b1, 32'h0, 4'h0);
    drive(1, 1'b0, 2'd2, 1'b0, 32'h0, 4'h0);
    for (int n = 0; n < 6; n++) begin
      #1;
      exp_r = (n % 2 == 1) ? 2'b10 : 2'b01;
      total++; if (req_ready !== exp_r) begin bad++; $display("FAIL alt_ready[%0d] got=%b want=%b", n, req_ready, exp_r); end
      if (n > 0) begin
        exp_r = (n % 2 == 1) ? 2'b01 : 2'b10;
        exp_d = (n % 2 == 1) ? 32'h1000_0001 : 32'h1000_0004;
        total++; if (rsp_valid !== exp_r || rsp_data !== exp_d) begin bad++; $display("FAIL alt_rsp[%0d] got=%b/%h want=%b/%h", n, rsp_valid, rsp_data, exp_r, exp_d); end
      end
      cyc();
    end
    idle(); #1;
    total++; if (rsp_valid !== 2'b10 || rsp_data !== 32'h1000_0004) begin bad++; $display("FAIL alt_last_rsp got=%b/%h want=10/10000004", rsp_valid, rsp_data); end
    total++; if (gnt_cnt !== 32'h0003_0003) begin bad++; $display("FAIL alt_cnt got=%h want=00030003", gnt_cnt); end
    cyc();
  endtask

  task automatic test_mask();
    idle(); drive(0, 1'b1, 2'd0, 1'b0, 32'h1122_3344, 4'hF); #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL mask_w0_ready got=%b want=01", req_ready); end
    cyc();
    idle(); drive(1, 1'b1, 2'd0, 1'b0, 32'hAABB_CCDD, 4'hC); #1;
    total++; if (req_ready !== 2'b10 || w_wmask !== 4'hC) begin bad++; $display("FAIL mask_w1 got=%b/%h want=10/c", req_ready, w_wmask); end
    cyc();
    idle(); drive(1, 1'b0, 2'd0, 1'b0, 32'h0, 4'h0); #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL mask_rd_ready got=%b want=10", req_ready); end
    cyc();
    idle(); #1;
    total++; if (rsp_valid !== 2'b10 || rsp_data !== 32'hAABB_3344) begin bad++; $display("FAIL mask_rsp got=%b/%h want=10/aabb3344", rsp_valid, rsp_data); end
    cyc();
  endtask

  task automatic test_oob();
    idle(); drive(0, 1'b0, 2'd3, 1'b0, 32'h0, 4'h0); #1;
    total++; if (oob_err !== 1'b0) begin bad++; $display("FAIL oob_before got=%b want=0", oob_err); end
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL oob_ready got=%b want=01", req_ready); end
    total++; if ({w_en, w_re, w_we} !== 3'b000) begin bad++; $display("FAIL oob_cmd got=%b want=000", {w_en, w_re, w_we}); end
    cyc();
    idle(); #1;
    total++; if (oob_err !== 1'b1) begin bad++; $display("FAIL oob_flag got=%b want=1", oob_err); end
    total++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h0) begin bad++; $display("FAIL oob_rsp got=%b/%h want=01/0", rsp_valid, rsp_data); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL oob_proto got=%b want=0", proto_err); end
    cyc();
  endtask

  task automatic test_hold();
    idle(); drive(0, 1'b0, 2'd2, 1'b1, 32'h0, 4'h0); #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL hold_pre_ready got=%b want=01", req_ready); end
    cyc();
    idle(); hold = 1'b1;
    drive(0, 1'b0, 2'd2, 1'b1, 32'h0, 4'h0);
    drive(1, 1'b0, 2'd0, 1'b1, 32'h0, 4'h0);
    for (int n = 0; n < 4; n++) begin
      #1;
      total++; if (req_ready !== 2'b00 || w_en !== 1'b0) begin bad++; $display("FAIL hold_block[%0d] got=%b/%b want=00/0", n, req_ready, w_en); end
      if (n == 0) begin
        total++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h1000_0005) begin bad++; $display("FAIL hold_inflight got=%b/%h want=01/10000005", rsp_valid, rsp_data); end
      end
      cyc();
    end
    hold = 1'b0; #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL hold_release got=%b want=10", req_ready); end
    cyc(); #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL hold_next got=%b want=01", req_ready); end
    total++; if (rsp_valid !== 2'b10 || rsp_data !== 32'h1000_0001) begin bad++; $display("FAIL hold_rsp got=%b/%h want=10/10000001", rsp_valid, rsp_data); end
    cyc();
    idle();
    cyc();
  endtask

  task automatic test_reset_mid();
    idle(); drive(0, 1'b0, 2'd1, 1'b0, 32'h0, 4'h0); #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rmid_ready got=%b want=01", req_ready); end
    cyc();
    rst = 1'b1; drive(1, 1'b0, 2'd0, 1'b0, 32'h0, 4'h0); #1;
    total++; if (req_ready !== 2'b00 || w_en !== 1'b0) begin bad++; $display("FAIL rmid_cmd got=%b/%b want=00/0", req_ready, w_en); end
    total++; if (rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin bad++; $display("FAIL rmid_rsp got=%b/%h want=00/0", rsp_valid, rsp_data); end
    cyc();
    rst = 1'b0; idle(); inj_rv = 1'b1; #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rmid_stale got=%b want=00", rsp_valid); end
    cyc();
    inj_rv = 1'b0; #1;
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rmid_proto got=%b want=0", proto_err); end
    total++; if (gnt_cnt !== 32'h0 || oob_err !== 1'b0) begin bad++; $display("FAIL rmid_clear got=%h/%b want=0/0", gnt_cnt, oob_err); end
    cyc();
  endtask

  task automatic test_proto();
    do_reset();
    drop_rv = 1'b1;
    drive(0, 1'b0, 2'd0, 1'b0, 32'h0, 4'h0); #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL miss_ready got=%b want=01", req_ready); end
    cyc();
    idle(); #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL miss_rsp got=%b want=00", rsp_valid); end
    cyc();
    drop_rv = 1'b0; #1;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL miss_proto got=%b want=1", proto_err); end
    do_reset();
    #1;
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL spur_clear got=%b want=0", proto_err); end
    inj_rv = 1'b1; #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL spur_rsp got=%b want=00", rsp_valid); end
    cyc();
    inj_rv = 1'b0; #1;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL spur_proto got=%b want=1", proto_err); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_alternate();
    test_mask();
    test_oob();
    test_hold();
    test_reset_mid();
    test_proto();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
